des_iter_ctrl: RTL
==================

Name: des_iter_ctrl

Overview:
- Iterative DES engine controller that sequences one shared `s_function` instance through the 16 DES rounds of a 64-bit block.
- Owns the L/R state registers, the C/D key-schedule registers and round counter, plus the IP, FP, E, P, PC1 and PC2 permutations.
- Provides a start/done handshake to the surrounding system.
- Supports encrypt and decrypt by running the key schedule forwards or backwards.

Parameters:
SBOX_REG, 0, 0 = one cycle per round; 1 = register `s_function` output, so each round takes 2 cycles (F phase, then U phase).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on a rising edge where ready=1
- decrypt  input  1  mode, sampled with start; 1 = decrypt
- key  input  64  DES key, sampled with start; bit 63 = DES bit 1; parity bits ignored by PC1
- din  input  64  plaintext or ciphertext block, sampled with start
- abort  input  1  synchronous cancel of an operation in progress
- ready  output  1  high in IDLE
- busy  output  1  high while rounds are executing
- done  output  1  one-cycle pulse; dout is valid from this cycle
- dout  output  64  result block; holds until the next done
- round  output  4  index of the round being executed, 0..15; 0 when idle

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; L, R, C, D, dout = 0; round=0.
  - done=0, busy=0, ready=1.
  - An operation in flight is discarded without a done.
- States: IDLE, RUN_F, RUN_U. RUN_U exists only when SBOX_REG=1.
- IDLE:
  - On start=1 at a clock edge, capture mode.
  - Load {L,R} = IP(din) and {C,D} = PC1(key).
  - Set round=0 and go to RUN_F.
  - start while busy is ignored; it is not queued.
- Key schedule:
  - Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt, round i (1-based): rotate C and D left by S[i], register the rotated values, and use PC2 of the rotated values as Ki.
  - Decrypt, round i: rotate C and D right by 0 when i=1, otherwise by S[18-i]; register and use the same way. This yields K16..K1.
- Round function:
  - `s_function` input = E(R) XOR Ki; its 32-bit output goes to P.
  - Next L = R; next R = L XOR P(s_out).
- SBOX_REG=0:
  - Each RUN_F edge completes one round and increments round.
  - On the edge completing round 15 (the 16th round): dout = FP({R,L}) (final swap), done=1 for the next cycle, go to IDLE.
  - Latency: done is high in the 16th cycle after the start edge.
- SBOX_REG=1:
  - RUN_F registers s_out only; the key rotation commits in RUN_F.
  - RUN_U applies P and updates L/R.
  - Latency: done is high in the 32nd cycle after the start edge.
- busy=1 from the start edge until the edge that raises done. ready = ~busy.
- done and start in the same cycle: ready=1 during the done cycle, so start is accepted with no dead cycle. dout keeps the previous result until the new done.
- abort=1 while busy:
  - Return to IDLE at the next edge; round=0.
  - No done; dout unchanged.
  - abort in IDLE has no effect. abort together with start in IDLE: abort wins, and the start is not accepted.
- round wraps only via return to IDLE; it never exceeds 15.
- decrypt, key and din may change freely after the start edge. Only the captured values are used.

Test Plan:
1. Encrypt, key=133457799BBCDFF1, din=0123456789ABCDEF.
   -> dout=85E813540F0AB405; done 1 cycle wide, 16 cycles after start (SBOX_REG=0).
2. Decrypt, key=133457799BBCDFF1, din=85E813540F0AB405.
   -> dout=0123456789ABCDEF.
   Also: key=0E329232EA6D0D73, encrypt 8787878787878787 -> 0000000000000000.
3. Back-to-back: raise start in the done cycle of test 1 with a new block.
   -> second start accepted immediately; the first dout holds until the second done; both results correct.
4. abort at round=7, then rst_n pulsed low mid-run on a second operation.
   -> no done, dout unchanged by the abort; reset clears all outputs to 0 within the same cycle and ready=1.
5. start asserted while busy=1 with a different din.
   -> ignored; result equals the first operation; no extra done.
6. SBOX_REG=1 rerun of tests 1–2.
   -> same dout values; done exactly 32 cycles after start; round advances every 2 cycles.

Source files
------------

// File: rtl/des_iter_ctrl.sv
// Iterative DES engine controller.
// s_function: the eight DES S-boxes, 48-bit input -> 32-bit output.
// des_iter_ctrl: runs the 16 DES rounds of one 64-bit block through a single
// shared s_function, owning L/R, C/D, round counter and all permutations.
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, decrypt    request (taken when ready=1) and mode (1 = decrypt)
//   key, din          64-bit key and data block, sampled with start
//   abort             cancel the operation in progress
//   ready, busy       idle / rounds executing
//   done, dout        one-cycle completion pulse, result block (held)
//   round             round being executed, 0..15 (0 when idle)
// SBOX_REG=1 registers the S-box output, so each round takes two cycles.

module s_function (
    input  logic [47:0] sin,
    output logic [31:0] sout
);

    localparam int unsigned SB [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
    };

    // Row is the outer bit pair of the 6-bit chunk, column the inner four.
    function automatic logic [3:0] sbox(input int unsigned b, input logic [5:0] c);
        int unsigned idx;
        idx = b * 64 + 32'({c[5], c[0]}) * 16 + 32'(c[4:1]);
        return 4'(SB[idx]);
    endfunction

    always_comb begin
        sout = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            sout[31 - 4*b -: 4] = sbox(b, sin[47 - 6*b -: 6]);
        end
    end

endmodule

module des_iter_ctrl #(
    parameter int unsigned SBOX_REG = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic [63:0] din,
    input  logic        abort,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [63:0] dout,
    output logic [3:0]  round
);

    // Permutation tables use DES bit numbering: bit 1 is the MSB.
    localparam int unsigned IP_T [64] = '{
        58,50,42,34,26,18,10, 2,60,52,44,36,28,20,12, 4,
        62,54,46,38,30,22,14, 6,64,56,48,40,32,24,16, 8,
        57,49,41,33,25,17, 9, 1,59,51,43,35,27,19,11, 3,
        61,53,45,37,29,21,13, 5,63,55,47,39,31,23,15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8,48,16,56,24,64,32,39, 7,47,15,55,23,63,31,
        38, 6,46,14,54,22,62,30,37, 5,45,13,53,21,61,29,
        36, 4,44,12,52,20,60,28,35, 3,43,11,51,19,59,27,
        34, 2,42,10,50,18,58,26,33, 1,41, 9,49,17,57,25};
    localparam int unsigned E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,
        12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,
        22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};
    localparam int unsigned P_T [32] = '{
        16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    localparam int unsigned PC1_T [56] = '{
        57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
        10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    localparam int unsigned PC2_T [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,
        23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,
        44,49,39,56,34,53,46,42,50,36,29,32};

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[63 - i] = x[64 - IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[63 - i] = x[64 - FP_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[47 - i] = x[32 - E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned i = 0; i < 32; i++) y[31 - i] = x[32 - P_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int unsigned i = 0; i < 56; i++) y[55 - i] = x[64 - PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[47 - i] = x[56 - PC2_T[i]];
        return y;
    endfunction

    // Encrypt rotates left by S[r+1]; decrypt rotates right by 0 on the
    // first round and S[17-r] afterwards, which walks C/D back from C16=C0.
    function automatic logic [1:0] shift_amt(input logic [3:0] r, input logic dec);
        logic one;
        one = (r == 4'd1) || (r == 4'd8) || (r == 4'd15);
        if (dec) return (r == 4'd0) ? 2'd0 : (one ? 2'd1 : 2'd2);
        else     return (one || r == 4'd0) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic dec,
                                          input logic [1:0] n);
        logic [27:0] y;
        y = v;
        if (dec) begin
            if (n == 2'd1)      y = {v[0], v[27:1]};
            else if (n == 2'd2) y = {v[1:0], v[27:2]};
        end else begin
            if (n == 2'd1)      y = {v[26:0], v[27]};
            else if (n == 2'd2) y = {v[25:0], v[27:26]};
        end
        return y;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN_F, RUN_U} state_t;

    state_t      state_q, state_d;
    logic [31:0] l_q, r_q, sreg_q;
    logic [27:0] c_q, d_q;
    logic        dec_q, done_q;
    logic [3:0]  rnd_q;
    logic [63:0] dout_q;

    logic        load, rot_en, sreg_en, lr_en, finish, rnd_inc, rnd_clr;
    logic [1:0]  shamt;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey, sf_in;
    logic [31:0] s_out, p_out;

    always_comb begin
        shamt  = shift_amt(rnd_q, dec_q);
        c_rot  = rot28(c_q, dec_q, shamt);
        d_rot  = rot28(d_q, dec_q, shamt);
        subkey = pc2_f({c_rot, d_rot});
        sf_in  = e_f(r_q) ^ subkey;
        p_out  = p_f((SBOX_REG != 0) ? sreg_q : s_out);
    end

    s_function u_sf (
        .sin  (sf_in),
        .sout (s_out)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        rot_en  = 1'b0;
        sreg_en = 1'b0;
        lr_en   = 1'b0;
        finish  = 1'b0;
        rnd_inc = 1'b0;
        rnd_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    state_d = RUN_F;
                end
            end
            RUN_F: begin
                if (abort) begin
                    rnd_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    rot_en = 1'b1;
                    if (SBOX_REG != 0) begin
                        sreg_en = 1'b1;
                        state_d = RUN_U;
                    end else begin
                        lr_en = 1'b1;
                        if (rnd_q == 4'd15) begin
                            finish  = 1'b1;
                            rnd_clr = 1'b1;
                            state_d = IDLE;
                        end else begin
                            rnd_inc = 1'b1;
                        end
                    end
                end
            end
            RUN_U: begin
                if (abort) begin
                    rnd_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    lr_en = 1'b1;
                    if (rnd_q == 4'd15) begin
                        finish  = 1'b1;
                        rnd_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rnd_inc = 1'b1;
                        state_d = RUN_F;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q    <= '0;
            r_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            sreg_q <= '0;
            dec_q  <= 1'b0;
            rnd_q  <= '0;
            dout_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                {l_q, r_q} <= ip_f(din);
                {c_q, d_q} <= pc1_f(key);
                dec_q      <= decrypt;
            end
            if (rot_en) begin
                c_q <= c_rot;
                d_q <= d_rot;
            end
            if (sreg_en) sreg_q <= s_out;
            if (lr_en) begin
                l_q <= r_q;
                r_q <= l_q ^ p_out;
            end
            // Final swap: output is FP(R16 || L16).
            if (finish) dout_q <= fp_f({l_q ^ p_out, r_q});
            if (load || rnd_clr) rnd_q <= '0;
            else if (rnd_inc)    rnd_q <= rnd_q + 4'd1;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign dout  = dout_q;
    assign round = rnd_q;

endmodule
